// File: rtl/ps2_receiver.sv
// PS/2 receiver: synchronises and deglitches the PS/2 clock and data pins and deserialises 11-bit frames into bytes.
// Latency: the byte strobe rises FILTER_LEN+2 i_clk cycles after the raw stop-bit clock fall reaches i_clk.
// Backpressure: none. Every byte is a single-cycle strobe that must be taken when it appears; there is no flow control.
//
// Ports:
//   i_clk        system clock, the only clock
//   i_rst_n      asynchronous active-low reset
//   i_ps2_clk    raw PS/2 clock pin, asynchronous to i_clk
//   i_ps2_data   raw PS/2 data pin, asynchronous to i_clk
//   o_data       last good byte, held until the next good frame
//   o_data_valid one-cycle pulse when o_data updates
//   o_frame_err  one-cycle pulse on a parity error, a stop-bit error or a timeout

module ps2_receiver #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 10000
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_ps2_clk,
    input  logic       i_ps2_data,
    output logic [7:0] o_data,
    output logic       o_data_valid,
    output logic       o_frame_err
);

    localparam int              TO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    // Two-flop synchronisers. They reset to 1, the idle level of the bus.
    logic clk_s1;
    logic clk_s2;
    logic dat_s1;
    logic dat_s2;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            clk_s1 <= 1'b1;
            clk_s2 <= 1'b1;
            dat_s1 <= 1'b1;
            dat_s2 <= 1'b1;
        end else begin
            clk_s1 <= i_ps2_clk;
            clk_s2 <= clk_s1;
            dat_s1 <= i_ps2_data;
            dat_s2 <= dat_s1;
        end
    end

    // Clock deglitch filter. flt_clk changes level only after FILTER_LEN
    // identical samples, so any shorter pulse in either direction is absorbed.
    logic [FILTER_LEN-1:0] flt_sr;
    logic                  flt_clk;
    logic                  fall;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            flt_sr  <= '1;
            flt_clk <= 1'b1;
        end else begin
            flt_sr <= {flt_sr[FILTER_LEN-2:0], clk_s2};
            if (flt_sr == '1) begin
                flt_clk <= 1'b1;
            end else if (flt_sr == '0) begin
                flt_clk <= 1'b0;
            end
        end
    end

    // fall is high in the single cycle before flt_clk drops. The data bit
    // belonging to that clock edge is dat_s2 in the same cycle.
    assign fall = flt_clk & (flt_sr == '0);

    // Frame FSM and timeout counter.
    state_t          state;
    logic [7:0]      sh;
    logic [2:0]      bit_cnt;
    logic            par;
    logic [TO_W-1:0] to_cnt;
    logic            timeout;

    // A fall in the same cycle takes priority over the timeout: the bit is
    // still processed, and the counter restarts.
    assign timeout = (state != ST_IDLE) && (to_cnt == TO_LAST) && !fall;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state        <= ST_IDLE;
            sh           <= '0;
            bit_cnt      <= '0;
            par          <= 1'b0;
            to_cnt       <= '0;
            o_data       <= '0;
            o_data_valid <= 1'b0;
            o_frame_err  <= 1'b0;
        end else begin
            o_data_valid <= 1'b0;
            o_frame_err  <= 1'b0;

            if (state == ST_IDLE || fall) begin
                to_cnt <= '0;
            end else begin
                to_cnt <= to_cnt + TO_W'(1);
            end

            if (fall) begin
                case (state)
                    ST_IDLE: begin
                        // A high bit here is a false start and is ignored
                        // without raising an error.
                        if (!dat_s2) begin
                            state   <= ST_DATA;
                            bit_cnt <= '0;
                        end
                    end
                    ST_DATA: begin
                        sh      <= {dat_s2, sh[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            state <= ST_PARITY;
                        end
                    end
                    ST_PARITY: begin
                        par   <= dat_s2;
                        state <= ST_STOP;
                    end
                    ST_STOP: begin
                        // The frame is good when the stop bit is high and
                        // the parity is odd over the data and parity bits.
                        if (dat_s2 && (^{sh, par})) begin
                            o_data       <= sh;
                            o_data_valid <= 1'b1;
                        end else begin
                            o_frame_err  <= 1'b1;
                        end
                        state <= ST_IDLE;
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end else if (timeout) begin
                // The device stopped clocking in mid-frame, so the
                // partial frame is discarded.
                state       <= ST_IDLE;
                sh          <= '0;
                bit_cnt     <= '0;
                o_frame_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ps2_receiver.sv
module tb_ps2_receiver;

    localparam int F = 8;
    localparam int T = 1000;

    logic       i_clk      = 1'b0;
    logic       i_rst_n    = 1'b0;
    logic       i_ps2_clk  = 1'b1;
    logic       i_ps2_data = 1'b1;
    logic [7:0] o_data;
    logic       o_data_valid;
    logic       o_frame_err;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int both_hi  = 0;

    // Observed output events: kind 1 = byte strobe, kind 2 = frame error.
    int         ev_kind[$];
    logic [7:0] ev_dat[$];
    int         ev_cyc[$];

    // Model state: the byte that o_data should currently hold.
    logic [7:0] exp_data = 8'h00;

    ps2_receiver #(
        .FILTER_LEN    (F),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_ps2_clk   (i_ps2_clk),
        .i_ps2_data  (i_ps2_data),
        .o_data      (o_data),
        .o_data_valid(o_data_valid),
        .o_frame_err (o_frame_err)
    );

    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) cyc <= cyc + 1;

    // The monitor samples on the falling edge. cyc then holds the index of
    // the rising edge that produced the sampled values.
    always @(negedge i_clk) begin
        if (i_rst_n) begin
            if (o_data_valid && o_frame_err) both_hi++;
            if (o_data_valid) begin
                ev_kind.push_back(1);
                ev_dat.push_back(o_data);
                ev_cyc.push_back(cyc);
            end
            if (o_frame_err) begin
                ev_kind.push_back(2);
                ev_dat.push_back(o_data);
                ev_cyc.push_back(cyc);
            end
        end
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, need finish");
        $fatal(1);
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge i_clk);
    endtask

    task automatic clr_ev();
        ev_kind.delete();
        ev_dat.delete();
        ev_cyc.delete();
    endtask

    // Build a frame. Bit 0 is the start bit, bits 8:1 are the data LSB first,
    // bit 9 is parity and bit 10 is the stop bit.
    function automatic logic [10:0] mk_frame(input logic [7:0] d, input logic p, input logic s);
        return {s, p, d, 1'b0};
    endfunction

    // Reference rule for a good frame: start bit 0, stop bit 1, odd parity.
    function automatic bit frame_ok(input logic [10:0] f);
        return (f[0] == 1'b0) && (f[10] == 1'b1) && ((^f[9:1]) == 1'b1);
    endfunction

    // Device-side driver. Data changes at the start of each high phase.
    // The optional glitches are a 3-cycle low pulse in the middle of each high
    // phase and a 3-cycle high pulse in the middle of each low phase.
    // last_e0 is the cycle index of edge 0 for the final clock fall.
    task automatic send_bits(input logic [10:0] b, input int n, input int half,
                             input bit glitch, output int last_e0);
        last_e0 = 0;
        for (int i = 0; i < n; i++) begin
            i_ps2_data = b[i];
            if (glitch) begin
                wait_cyc(half / 2);
                i_ps2_clk = 1'b0;
                wait_cyc(3);
                i_ps2_clk = 1'b1;
                wait_cyc(half - half / 2 - 3);
            end else begin
                wait_cyc(half);
            end
            i_ps2_clk = 1'b0;
            last_e0   = cyc + 1;
            if (glitch) begin
                wait_cyc(half / 2);
                i_ps2_clk = 1'b1;
                wait_cyc(3);
                i_ps2_clk = 1'b0;
                wait_cyc(half - half / 2 - 3);
            end else begin
                wait_cyc(half);
            end
            i_ps2_clk = 1'b1;
        end
        i_ps2_data = 1'b1;
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0;
        wait_cyc(3);
        n_checks++;
        if (o_data !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_data: got %h need 00", o_data);
        end
        n_checks++;
        if (o_data_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_valid: got %b need 0", o_data_valid);
        end
        n_checks++;
        if (o_frame_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_err: got %b need 0", o_frame_err);
        end
        i_rst_n = 1'b1;
        wait_cyc(20);
        clr_ev();
    endtask

    task automatic test_single();
        int e;
        clr_ev();
        send_bits(mk_frame(8'h1D, 1'b1, 1'b1), 11, 200, 1'b0, e);
        wait_cyc(20);
        exp_data = 8'h1D;
        n_checks++;
        if (ev_kind.size() !== 1) begin
            n_fail++;
            $display("FAIL single_count: got %0d events need 1", ev_kind.size());
        end
        if (ev_kind.size() > 0) begin
            n_checks++;
            if (ev_kind[0] !== 1 || ev_dat[0] !== 8'h1D) begin
                n_fail++;
                $display("FAIL single_event: got kind %0d data %h need kind 1 data 1d", ev_kind[0], ev_dat[0]);
            end
            n_checks++;
            if (ev_cyc[0] !== e + F + 2) begin
                n_fail++;
                $display("FAIL single_latency: got cycle %0d need %0d", ev_cyc[0], e + F + 2);
            end
        end
        n_checks++;
        if (o_data !== exp_data) begin
            n_fail++;
            $display("FAIL single_hold: got %h need %h", o_data, exp_data);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] b [3];
        int         e [3];
        b[0] = 8'hE0;
        b[1] = 8'hF0;
        b[2] = 8'h75;
        clr_ev();
        for (int i = 0; i < 3; i++) begin
            send_bits(mk_frame(b[i], ~^b[i], 1'b1), 11, 40, 1'b0, e[i]);
        end
        wait_cyc(10);
        n_checks++;
        if (ev_kind.size() !== 3) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d events need 3", ev_kind.size());
        end
        for (int i = 0; i < 3 && i < ev_kind.size(); i++) begin
            n_checks++;
            if (ev_kind[i] !== 1 || ev_dat[i] !== b[i] || ev_cyc[i] !== e[i] + F + 2) begin
                n_fail++;
                $display("FAIL b2b_event%0d: got kind %0d data %h cycle %0d need kind 1 data %h cycle %0d",
                         i, ev_kind[i], ev_dat[i], ev_cyc[i], b[i], e[i] + F + 2);
            end
        end
        exp_data = 8'h75;
    endtask

    task automatic test_bad_frames();
        logic [10:0] f [2];
        int          e;
        f[0] = mk_frame(8'h1D, 1'b0, 1'b1);
        f[1] = mk_frame(8'h1D, 1'b1, 1'b0);
        for (int k = 0; k < 2; k++) begin
            clr_ev();
            send_bits(f[k], 11, 40, 1'b0, e);
            wait_cyc(10);
            n_checks++;
            if (ev_kind.size() !== 1) begin
                n_fail++;
                $display("FAIL bad%0d_count: got %0d events need 1", k, ev_kind.size());
            end
            if (ev_kind.size() > 0) begin
                n_checks++;
                if (ev_kind[0] !== 2 || ev_cyc[0] !== e + F + 2) begin
                    n_fail++;
                    $display("FAIL bad%0d_event: got kind %0d cycle %0d need kind 2 cycle %0d",
                             k, ev_kind[0], ev_cyc[0], e + F + 2);
                end
            end
            n_checks++;
            if (o_data !== exp_data) begin
                n_fail++;
                $display("FAIL bad%0d_hold: got %h need %h", k, o_data, exp_data);
            end
        end
    endtask

    task automatic test_timeout();
        int e;
        clr_ev();
        send_bits(mk_frame(8'h05, 1'b0, 1'b1), 4, 40, 1'b0, e);
        wait_cyc(T + F + 40);
        n_checks++;
        if (ev_kind.size() !== 1) begin
            n_fail++;
            $display("FAIL timeout_count: got %0d events need 1", ev_kind.size());
        end
        if (ev_kind.size() > 0) begin
            n_checks++;
            if (ev_kind[0] !== 2 || ev_cyc[0] !== e + F + 2 + T) begin
                n_fail++;
                $display("FAIL timeout_event: got kind %0d cycle %0d need kind 2 cycle %0d",
                         ev_kind[0], ev_cyc[0], e + F + 2 + T);
            end
        end
        clr_ev();
        send_bits(mk_frame(8'hF0, 1'b1, 1'b1), 11, 40, 1'b0, e);
        wait_cyc(10);
        n_checks++;
        if (ev_kind.size() !== 1 || (ev_kind.size() > 0 && (ev_kind[0] !== 1 || ev_dat[0] !== 8'hF0))) begin
            n_fail++;
            $display("FAIL timeout_recover: got %0d events first data %h need one byte f0",
                     ev_kind.size(), o_data);
        end
        exp_data = 8'hF0;
    endtask

    task automatic test_glitch();
        int e;
        clr_ev();
        i_ps2_clk = 1'b0;
        wait_cyc(3);
        i_ps2_clk = 1'b1;
        wait_cyc(60);
        n_checks++;
        if (ev_kind.size() !== 0) begin
            n_fail++;
            $display("FAIL glitch_idle: got %0d events need 0", ev_kind.size());
        end
        clr_ev();
        send_bits(mk_frame(8'h29, 1'b0, 1'b1), 11, 40, 1'b1, e);
        wait_cyc(10);
        n_checks++;
        if (ev_kind.size() !== 1) begin
            n_fail++;
            $display("FAIL glitch_count: got %0d events need 1", ev_kind.size());
        end
        if (ev_kind.size() > 0) begin
            n_checks++;
            if (ev_kind[0] !== 1 || ev_dat[0] !== 8'h29 || ev_cyc[0] !== e + F + 2) begin
                n_fail++;
                $display("FAIL glitch_event: got kind %0d data %h cycle %0d need kind 1 data 29 cycle %0d",
                         ev_kind[0], ev_dat[0], ev_cyc[0], e + F + 2);
            end
        end
        exp_data = 8'h29;
    endtask

    task automatic test_reset_mid();
        logic [10:0] f;
        int          e;
        f = mk_frame(8'h5A, 1'b1, 1'b1);
        clr_ev();
        send_bits(f, 6, 40, 1'b0, e);
        i_rst_n = 1'b0;
        #1;
        n_checks++;
        if (o_data !== 8'h00 || o_data_valid !== 1'b0 || o_frame_err !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_now: got data %h valid %b err %b need 00 0 0",
                     o_data, o_data_valid, o_frame_err);
        end
        wait_cyc(5);
        n_checks++;
        if (o_data !== 8'h00 || o_data_valid !== 1'b0 || o_frame_err !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_hold: got data %h valid %b err %b need 00 0 0",
                     o_data, o_data_valid, o_frame_err);
        end
        i_rst_n  = 1'b1;
        exp_data = 8'h00;
        // The rest of the interrupted frame is data 0,1,0 then parity 1 and
        // stop 1. The first 0 looks like a start bit and only four more bits
        // follow, so the only possible outcome is a timeout error.
        send_bits(f >> 6, 5, 40, 1'b0, e);
        wait_cyc(T + F + 40);
        n_checks++;
        if (ev_kind.size() !== 1 || (ev_kind.size() > 0 && ev_kind[0] !== 2)) begin
            n_fail++;
            $display("FAIL midreset_junk: got %0d events need one timeout error", ev_kind.size());
        end
        n_checks++;
        if (o_data !== exp_data) begin
            n_fail++;
            $display("FAIL midreset_data: got %h need %h", o_data, exp_data);
        end
        clr_ev();
        send_bits(f, 11, 40, 1'b0, e);
        wait_cyc(10);
        n_checks++;
        if (ev_kind.size() !== 1 || o_data !== 8'h5A) begin
            n_fail++;
            $display("FAIL midreset_recover: got %0d events data %h need one byte 5a", ev_kind.size(), o_data);
        end
        exp_data = 8'h5A;
    endtask

    task automatic test_random();
        logic [7:0]  d;
        logic [10:0] f;
        logic        p;
        logic        s;
        int          r;
        int          half;
        int          e;
        bit          good;
        for (int n = 0; n < 24; n++) begin
            d    = 8'($urandom);
            r    = $urandom_range(0, 9);
            half = $urandom_range(20, 50);
            p    = (r == 6 || r == 7) ? ^d : ~^d;
            s    = (r >= 8) ? 1'b0 : 1'b1;
            f    = mk_frame(d, p, s);
            good = frame_ok(f);
            if (good) exp_data = d;
            clr_ev();
            send_bits(f, 11, half, 1'b0, e);
            wait_cyc(5);
            n_checks++;
            if (ev_kind.size() !== 1) begin
                n_fail++;
                $display("FAIL rand%0d_count: got %0d events need 1", n, ev_kind.size());
            end
            if (ev_kind.size() > 0) begin
                n_checks++;
                if (ev_kind[0] !== (good ? 1 : 2)) begin
                    n_fail++;
                    $display("FAIL rand%0d_kind: got %0d need %0d (frame %h)", n, ev_kind[0], good ? 1 : 2, f);
                end
                n_checks++;
                if (ev_cyc[0] !== e + F + 2) begin
                    n_fail++;
                    $display("FAIL rand%0d_latency: got cycle %0d need %0d", n, ev_cyc[0], e + F + 2);
                end
            end
            n_checks++;
            if (o_data !== exp_data) begin
                n_fail++;
                $display("FAIL rand%0d_data: got %h need %h", n, o_data, exp_data);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_bad_frames();
        test_timeout();
        test_glitch();
        test_reset_mid();
        test_random();
        n_checks++;
        if (both_hi !== 0) begin
            n_fail++;
            $display("FAIL exclusive_pulses: got %0d cycles with both high need 0", both_hi);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
